// File: rtl/datapath_sequencer.sv
// datapath_sequencer: fetch/decode/branch control FSM driving the single-cycle datapath.
// Optional retired-instruction counter (output `retired`) is built when SEQ_RETIRE_CNT_EN is defined.
module datapath_sequencer #(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
`ifdef SEQ_RETIRE_CNT_EN
  output logic [31:0]   retired,
`endif
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] pc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   inst,
  output logic          regwrite,
  output logic          regdst,
  output logic          extop,
  output logic          alusrc,
  output logic          memwrite,
  output logic          mem2reg,
  output logic [3:0]    aluctrl,
  output logic          shiftctrl,
  input  logic          zero,
  input  logic          msb
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_FETCH = 2'b01;
  localparam logic [1:0] ST_EXEC  = 2'b10;
  localparam logic [1:0] ST_HALT  = 2'b11;

  localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic       regwrite;
    logic       regdst;
    logic       extop;
    logic       alusrc;
    logic       memwrite;
    logic       mem2reg;
    logic [3:0] aluctrl;
    logic       shiftctrl;
    logic       is_beq;
    logic       is_bne;
    logic       is_bltz;
    logic       is_halt;
    logic       illegal;
  } dec_t;

  localparam int   DEC_W    = $bits(dec_t);
  localparam dec_t DEC_NONE = dec_t'({DEC_W{1'b0}});

  // Instruction word to control bundle; an illegal encoding yields all-zero controls.
  function automatic dec_t decode(input logic [31:0] iw);
    dec_t d;
    dec_t bad;
    d   = DEC_NONE;
    bad = DEC_NONE;
    bad.illegal = 1'b1;
    case (iw[31:26])
      6'b000000: begin
        d.regwrite = 1'b1;
        d.regdst   = 1'b1;
        case (iw[5:0])
          6'b100000: d.aluctrl = 4'b0010;
          6'b100010: d.aluctrl = 4'b0110;
          6'b100100: d.aluctrl = 4'b0000;
          6'b100101: d.aluctrl = 4'b0001;
          6'b101010: d.aluctrl = 4'b0111;
          6'b000000: begin
            d.aluctrl   = 4'b1000;
            d.shiftctrl = 1'b1;
          end
          default:   d.illegal = 1'b1;
        endcase
      end
      6'b001000: begin
        d.regwrite = 1'b1;
        d.extop    = 1'b1;
        d.alusrc   = 1'b1;
        d.aluctrl  = 4'b0010;
      end
      6'b100011: begin
        d.regwrite = 1'b1;
        d.extop    = 1'b1;
        d.alusrc   = 1'b1;
        d.mem2reg  = 1'b1;
        d.aluctrl  = 4'b0010;
      end
      6'b101011: begin
        d.extop    = 1'b1;
        d.alusrc   = 1'b1;
        d.memwrite = 1'b1;
        d.aluctrl  = 4'b0010;
      end
      6'b000100: begin
        d.extop   = 1'b1;
        d.aluctrl = 4'b0110;
        d.is_beq  = 1'b1;
      end
      6'b000101: begin
        d.extop   = 1'b1;
        d.aluctrl = 4'b0110;
        d.is_bne  = 1'b1;
      end
      6'b000001: begin
        // bltz computes rs+$0 so msb carries the sign of rs; rt must be zero
        if (iw[20:16] == 5'b00000) begin
          d.extop   = 1'b1;
          d.aluctrl = 4'b0010;
          d.is_bltz = 1'b1;
        end else begin
          d.illegal = 1'b1;
        end
      end
      6'b111111: d.is_halt = 1'b1;
      default:   d.illegal = 1'b1;
    endcase
    return d.illegal ? bad : d;
  endfunction

  logic [1:0]    state_r;
  logic [AW-1:0] pc_r;
  logic [31:0]   inst_r;
  dec_t          dec_r;
  logic          imem_req_r;
  logic          busy_r;
  logic          done_r;
  logic          err_r;

  logic          taken_s;
  logic [31:0]   imm_sext_s;
  logic [AW-1:0] pc_next_s;

  // Branch resolution and next-PC arithmetic for the instruction held in EXEC.
  always_comb begin
    taken_s    = 1'b0;
    imm_sext_s = {{16{inst_r[15]}}, inst_r[15:0]};
    pc_next_s  = pc_r + PC_ONE;
    if (dec_r.is_beq) begin
      taken_s = zero;
    end else if (dec_r.is_bne) begin
      taken_s = ~zero;
    end else if (dec_r.is_bltz) begin
      taken_s = msb;
    end else begin
      taken_s = 1'b0;
    end
    if (taken_s) begin
      pc_next_s = pc_r + PC_ONE + imm_sext_s[AW-1:0];
    end else begin
      pc_next_s = pc_r + PC_ONE;
    end
  end

  // Sequencer state, PC, instruction latch and registered control bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_PC;
      inst_r     <= 32'h0000_0000;
      dec_r      <= DEC_NONE;
      imem_req_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            pc_r       <= RESET_PC;
            err_r      <= 1'b0;
            imem_req_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= ST_FETCH;
          end else begin
            state_r <= state_r;
          end
        end
        ST_FETCH: begin
          if (imem_ack) begin
            inst_r     <= imem_rdata;
            dec_r      <= decode(imem_rdata);
            imem_req_r <= 1'b0;
            state_r    <= ST_EXEC;
          end else begin
            imem_req_r <= 1'b1;
          end
        end
        ST_EXEC: begin
          // controls are live only for this single cycle
          dec_r <= DEC_NONE;
          if (dec_r.illegal) begin
            err_r   <= 1'b1;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_HALT;
          end else if (dec_r.is_halt) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_HALT;
          end else begin
            pc_r       <= pc_next_s;
            imem_req_r <= 1'b1;
            state_r    <= ST_FETCH;
          end
        end
        default: begin
          dec_r      <= DEC_NONE;
          imem_req_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SEQ_RETIRE_CNT_EN
  logic [31:0] retired_r;

  // Saturating count of non-illegal instructions executed since the last start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_r <= 32'h0000_0000;
    end else if (((state_r == ST_IDLE) || (state_r == ST_HALT)) && start) begin
      retired_r <= 32'h0000_0000;
    end else if ((state_r == ST_EXEC) && !dec_r.illegal && (retired_r != 32'hFFFF_FFFF)) begin
      retired_r <= retired_r + 32'd1;
    end else begin
      retired_r <= retired_r;
    end
  end

  assign retired = retired_r;
`endif

  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign pc        = pc_r;
  assign imem_req  = imem_req_r;
  assign imem_addr = pc_r;
  assign inst      = inst_r;
  assign regwrite  = dec_r.regwrite;
  assign regdst    = dec_r.regdst;
  assign extop     = dec_r.extop;
  assign alusrc    = dec_r.alusrc;
  assign memwrite  = dec_r.memwrite;
  assign mem2reg   = dec_r.mem2reg;
  assign aluctrl   = dec_r.aluctrl;
  assign shiftctrl = dec_r.shiftctrl;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: directed programs plus randomized instruction
// streams checked against an instruction-level reference model (PC, controls, err, done).
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        zero = 1'b0;
  logic        msb = 1'b0;
  logic        busy, done, err, imem_req;
  logic [7:0]  pc, imem_addr;
  logic [31:0] inst;
  logic        regwrite, regdst, extop, alusrc, memwrite, mem2reg, shiftctrl;
  logic [3:0]  aluctrl;
  logic [10:0] ctrl_obs;
`ifdef SEQ_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  int          nvec = 0;
  int          nfail = 0;
  logic [7:0]  mpc = 8'd0;
  logic        merr = 1'b0;
  int          mret = 0;

  datapath_sequencer #(.AW(8), .RESET_PC(8'd0)) dut (
`ifdef SEQ_RETIRE_CNT_EN
    .retired(retired),
`endif
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst(inst), .regwrite(regwrite), .regdst(regdst),
    .extop(extop), .alusrc(alusrc), .memwrite(memwrite), .mem2reg(mem2reg),
    .aluctrl(aluctrl), .shiftctrl(shiftctrl), .zero(zero), .msb(msb)
  );

  assign ctrl_obs = {regwrite, regdst, extop, alusrc, memwrite, mem2reg, aluctrl, shiftctrl};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // 0 plain, 1 beq, 2 bne, 3 bltz, 4 halt, 5 illegal
  function automatic int classify(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    if (op == 6'h00) return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00}) ? 0 : 5;
    if (op == 6'h04) return 1;
    if (op == 6'h05) return 2;
    if (op == 6'h01) return (w[20:16] == 5'd0) ? 3 : 5;
    if (op == 6'h3F) return 4;
    if (op inside {6'h08, 6'h23, 6'h2B}) return 0;
    return 5;
  endfunction

  // {regwrite,regdst,extop,alusrc,memwrite,mem2reg,aluctrl[3:0],shiftctrl}
  function automatic logic [10:0] exp_ctrl(input logic [31:0] w);
    int c;
    c = classify(w);
    if (c >= 4) return 11'd0;
    if (c == 1 || c == 2) return {6'b001000, 4'b0110, 1'b0};
    if (c == 3) return {6'b001000, 4'b0010, 1'b0};
    case (w[31:26])
      6'h08: return {6'b101100, 4'b0010, 1'b0};
      6'h23: return {6'b101101, 4'b0010, 1'b0};
      6'h2B: return {6'b001110, 4'b0010, 1'b0};
      default: begin
        case (w[5:0])
          6'h20:   return {6'b110000, 4'b0010, 1'b0};
          6'h22:   return {6'b110000, 4'b0110, 1'b0};
          6'h24:   return {6'b110000, 4'b0000, 1'b0};
          6'h25:   return {6'b110000, 4'b0001, 1'b0};
          6'h2A:   return {6'b110000, 4'b0111, 1'b0};
          default: return {6'b110000, 4'b1000, 1'b1};
        endcase
      end
    endcase
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mpc = 8'd0;
    merr = 1'b0;
    mret = 0;
    check("start_pc", pc, 32'd0);
    check("start_err", err, 32'd0);
    check("start_busy", busy, 32'd1);
    check("start_req", imem_req, 32'd1);
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves at the negedge after EXEC.
  task automatic run_inst(input logic [31:0] w, input logic z, input logic m, input int dly);
    int  c;
    logic taken;
    logic [7:0] pc0;
    c = classify(w);
    pc0 = mpc;
    check("fetch_req", imem_req, 32'd1);
    check("fetch_addr", imem_addr, mpc);
    check("fetch_busy", busy, 32'd1);
    check("fetch_wr", {regwrite, memwrite}, 32'd0);
    for (int i = 0; i < dly; i++) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_req", imem_req, 32'd1);
      check("hold_pc", pc, mpc);
      check("hold_wr", {regwrite, memwrite}, 32'd0);
    end
    imem_rdata = w;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    zero = z;
    msb = m;
    start = 1'($urandom_range(0, 1));
    check("exec_ctrl", ctrl_obs, exp_ctrl(w));
    check("exec_inst", inst, w);
    check("exec_req", imem_req, 32'd0);
    check("exec_busy", busy, 32'd1);
    @(negedge clk);
    start = 1'b0;
    taken = (c == 1 && z) || (c == 2 && !z) || (c == 3 && m);
    if (c < 4) mpc = 8'(int'(mpc) + 1 + (taken ? int'($signed(w[15:0])) : 0));
    if (c < 5) mret++;
    if (c == 5) merr = 1'b1;
    if (c >= 4) begin
      check("halt_done", done, 32'd1);
      check("halt_busy", busy, 32'd0);
      check("halt_err", err, merr);
      check("halt_pc", pc, pc0);
      check("halt_ctrl", ctrl_obs, 32'd0);
      check("halt_req", imem_req, 32'd0);
      @(negedge clk);
      check("done_pulse", done, 32'd0);
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      check("halt_ack_ign", busy, 32'd0);
      check("halt_pc_hold", pc, pc0);
      check("halt_inst_hold", inst, w);
    end else begin
      check("next_pc", pc, mpc);
      check("next_req", imem_req, 32'd1);
      check("next_done", done, 32'd0);
      check("next_ctrl", ctrl_obs, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] w;
    int          k;
    logic [5:0]  f;

    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_ctrl", ctrl_obs, 32'd0);
    check("rst_req", imem_req, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_done", done, 32'd0);
    check("rst_err", err, 32'd0);
`ifdef SEQ_RETIRE_CNT_EN
    check("rst_retired", retired, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("idle_ack_busy", busy, 32'd0);
    check("idle_ack_inst", inst, 32'd0);

    // directed program: pc 0,1,2,3,4 -> beq back to 3 -> 4 -> 5 -> bltz 4 -> bltz 8 -> halt
    do_start();
    run_inst(32'h2005_0001, 1'b0, 1'b0, 1);
    run_inst(32'h0002_1400, 1'b0, 1'b0, 0);
    run_inst(32'h0047_302A, 1'b0, 1'b0, 2);
    run_inst(32'hAC43_0024, 1'b0, 1'b0, 0);
    run_inst(32'h1000_FFFE, 1'b1, 1'b0, 1);
    run_inst(32'h8C44_0028, 1'b0, 1'b0, 0);
    run_inst(32'h1000_FFFE, 1'b0, 1'b0, 0);
    run_inst(32'h0420_FFFE, 1'b0, 1'b1, 0);
    run_inst(32'h0420_0003, 1'b0, 1'b1, 0);
    run_inst(32'hFC00_0000, 1'b0, 1'b0, 0);
`ifdef SEQ_RETIRE_CNT_EN
    check("retired_prog", retired, mret);
`endif

    do_start();
    run_inst(32'h2005_0001, 1'b0, 1'b0, 0);
    run_inst(32'h2005_0001, 1'b0, 1'b0, 0);
    run_inst(32'hFC00_0000, 1'b0, 1'b0, 0);

    do_start();
    run_inst(32'hF800_0000, 1'b0, 1'b0, 0);
`ifdef SEQ_RETIRE_CNT_EN
    check("retired_illegal", retired, 32'd0);
`endif
    do_start();

    // reset while a fetch is outstanding
    rst_n = 1'b0;
    #1;
    check("rstf_req", imem_req, 32'd0);
    check("rstf_pc", pc, 32'd0);
    check("rstf_busy", busy, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstf_idle", busy, 32'd0);

    // reset during EXEC of a store kills the write strobe at once
    do_start();
    imem_rdata = 32'hAC43_0024;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("rste_mw_pre", memwrite, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rste_mw", memwrite, 32'd0);
    check("rste_busy", busy, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_start();
    for (int n = 0; n < 400; n++) begin
      w = $urandom;
      k = $urandom_range(0, 19);
      case (k)
        0:  begin w[31:26] = 6'h00; w[5:0] = 6'h20; end
        1:  begin w[31:26] = 6'h00; w[5:0] = 6'h22; end
        2:  begin w[31:26] = 6'h00; w[5:0] = 6'h24; end
        3:  begin w[31:26] = 6'h00; w[5:0] = 6'h25; end
        4:  begin w[31:26] = 6'h00; w[5:0] = 6'h2A; end
        5:  begin w[31:26] = 6'h00; w[5:0] = 6'h00; end
        6, 19: w[31:26] = 6'h08;
        7:  w[31:26] = 6'h23;
        8:  w[31:26] = 6'h2B;
        9, 10:  w[31:26] = 6'h04;
        11, 12: w[31:26] = 6'h05;
        13, 14: begin w[31:26] = 6'h01; w[20:16] = 5'd0; end
        15: w[31:26] = 6'h3F;
        16: begin
          do f = 6'($urandom_range(0, 63));
          while (f inside {6'h00, 6'h01, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B, 6'h3F});
          w[31:26] = f;
        end
        17: begin
          do f = 6'($urandom_range(0, 63));
          while (f inside {6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
          w[31:26] = 6'h00;
          w[5:0] = f;
        end
        default: begin w[31:26] = 6'h01; w[20:16] = 5'($urandom_range(1, 31)); end
      endcase
      run_inst(w, 1'($urandom), 1'($urandom), $urandom_range(0, 2));
      if (classify(w) >= 4) begin
`ifdef SEQ_RETIRE_CNT_EN
        check("retired_rand", retired, mret);
`endif
        do_start();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Control FSM that drives the single-cycle `datapath`. It owns the PC and fetches 32-bit instructions over a req/ack instruction-memory port.
- Decodes each instruction into the datapath control bundle: regwrite, regdst, extop, alusrc, memwrite, mem2reg, aluctrl, shiftctrl.
- Resolves branches from the datapath's zero/msb flags.
- Replaces the hand-driven control vectors used in datapath-level benches and becomes the top-level control for the processor.

Parameters:
- AW, 8, instruction address width; PC is word-addressed.
- RESET_PC, 0, PC value after reset and at each start.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begin execution at RESET_PC. Ignored unless in IDLE or HALT.
- busy  out  1  high in FETCH and EXEC.
- done  out  1  one-cycle pulse on entry to HALT.
- err  out  1  sticky; set on illegal opcode/funct; cleared by start or reset.
- pc  out  AW  current PC.
- imem_req  out  1  fetch request; held until ack.
- imem_addr  out  AW  equals pc while imem_req is high.
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  32  instruction word.
- inst  out  32  latched instruction to datapath.
- regwrite, regdst, extop, alusrc, memwrite, mem2reg, shiftctrl  out  1 each  datapath controls.
- aluctrl  out  4  datapath ALU select.
- zero, msb  in  1 each  datapath ALU flags, combinational in the EXEC cycle.

Behaviour:
- States: IDLE, FETCH, EXEC, HALT. Reset state is IDLE.
- Reset values: pc=RESET_PC, inst=0, all controls 0, aluctrl=0000, imem_req=0, busy=0, done=0, err=0.
- IDLE/HALT + start: pc←RESET_PC, err←0, go to FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack: inst←imem_rdata, go to EXEC.
  - No timeout; waits indefinitely.
- EXEC is exactly one cycle. Controls are driven combinationally from inst. regwrite and memwrite are asserted only in EXEC; they are 0 in every other state.
- Decode, as (regwrite, regdst, extop, alusrc, memwrite, mem2reg, aluctrl, shiftctrl):
  - R-type, opcode 000000: (1,1,0,0,0,0,x,0). aluctrl by funct:
    - add 100000 → 0010
    - sub 100010 → 0110
    - and 100100 → 0000
    - or 100101 → 0001
    - slt 101010 → 0111
  - sll, opcode 000000 funct 000000: (1,1,0,0,0,0,1000,1).
  - addi 001000: (1,0,1,1,0,0,0010,0).
  - lw 100011: (1,0,1,1,0,1,0010,0).
  - sw 101011: (0,0,1,1,1,0,0010,0).
  - beq 000100 / bne 000101: (0,0,1,0,0,0,0110,0).
  - bltz 000001 (rt must be 0): (0,0,1,0,0,0,0010,0). Adds rs+$0; msb is the sign.
  - halt 111111: all controls 0.
- PC update at the end of EXEC:
  - Taken branch: pc←pc+1+sext(imm16)[AW-1:0].
    - beq is taken if zero=1.
    - bne is taken if zero=0.
    - bltz is taken if msb=1.
  - Otherwise: pc←pc+1.
  - Arithmetic is modulo 2^AW; wrap-around is legal and silent.
- Next state after EXEC: FETCH. Exceptions:
  - halt → HALT with done pulse.
  - Illegal opcode, illegal funct, or bltz with rt≠0 → all controls forced 0 that cycle, err←1, HALT with done pulse.
- HALT holds pc and inst. Controls stay 0 until start.
- start during FETCH/EXEC is ignored.
- rst_n low mid-FETCH drops imem_req immediately (asynchronous). Mid-EXEC it suppresses the write strobes in that same cycle.
- imem_ack while not in FETCH is ignored.

Optional Feature:
- Macro: SEQ_RETIRE_CNT_EN.
- With the macro defined: extra output retired [31:0].
  - Reset to 0; cleared on accepted start.
  - Increments by 1 at each EXEC that is not illegal. Halt counts as retired.
  - Saturates at 32'hFFFFFFFF.
- Without the macro: port and counter are absent. All other behaviour is identical.

Test Plan:
- Program addi $5,$0,1 (0x20050001) with imem_ack a cycle after req → EXEC shows regwrite=1, alusrc=1, extop=1, aluctrl=0010; pc goes 0→1; 2 cycles per instruction.
- sll 0x00021400, then slt 0x0047302A → EXEC controls 1,1,0,0,0,0,1000,1, then 1,1,0,0,0,0,0111,0.
- sw 0xAC430024 then lw 0x8C440028 → sw: memwrite=1, regwrite=0. lw: mem2reg=1. Neither write strobe is high in FETCH.
- beq at pc=4 with imm=-2 and zero=1 → pc=3. Same with zero=0 → pc=5. bltz with msb=1, imm=+3 at pc=4 → pc=8.
- Opcode 0x3F at pc=2 → done pulses once, busy=0, pc stays 2. Opcode 0x3E → err=1, controls 0. A subsequent start clears err and refetches at RESET_PC.
- rst_n asserted while imem_req=1 with ack withheld → imem_req=0 immediately; pc=RESET_PC, state IDLE. With SEQ_RETIRE_CNT_EN, 5 instructions plus halt → retired=6.
